// File: rtl/alu_share_arb_if.sv
// Request/response handshakes and shared-ALU drive bundle for alu_share_arb.
interface alu_share_arb_if #(
    parameter int unsigned D_WIDTH    = 32,
    parameter int unsigned CTRL_WIDTH = 3
);
    logic                  req0_valid, req1_valid;
    logic                  req0_ready, req1_ready;
    logic [CTRL_WIDTH-1:0] req0_ctrl, req1_ctrl;
    logic [D_WIDTH-1:0]    req0_op1, req0_op2, req1_op1, req1_op2;

    logic                  rsp0_valid, rsp1_valid;
    logic                  rsp0_ready, rsp1_ready;
    logic [D_WIDTH-1:0]    rsp0_data, rsp1_data;
    logic                  rsp0_eq, rsp1_eq;

    logic [CTRL_WIDTH-1:0] alu_ctrl;
    logic [D_WIDTH-1:0]    alu_op1, alu_op2;
    logic [D_WIDTH-1:0]    alu_out;
    logic                  alu_eq;

    // Requesters plus the shared ALU on one side, the arbiter on the other.
    modport master (
        output req0_valid, req1_valid, req0_ctrl, req1_ctrl,
               req0_op1, req0_op2, req1_op1, req1_op2,
               rsp0_ready, rsp1_ready, alu_out, alu_eq,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_data, rsp1_data, rsp0_eq, rsp1_eq,
               alu_ctrl, alu_op1, alu_op2
    );

    modport slave (
        input  req0_valid, req1_valid, req0_ctrl, req1_ctrl,
               req0_op1, req0_op2, req1_op1, req1_op2,
               rsp0_ready, rsp1_ready, alu_out, alu_eq,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_data, rsp1_data, rsp0_eq, rsp1_eq,
               alu_ctrl, alu_op1, alu_op2
    );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester arbiter sharing one ALU through a one-entry issue register.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed req0 priority; default is round-robin.
module alu_share_arb #(
    parameter int unsigned D_WIDTH    = 32,
    parameter int unsigned CTRL_WIDTH = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_share_arb_if.slave bus
);

    typedef struct packed {
        logic                  owner;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic [D_WIDTH-1:0]    op1;
        logic [D_WIDTH-1:0]    op2;
    } issue_t;

    logic                    issue_valid_q, issue_valid_d;
    issue_t                  issue_q, issue_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic [1:0][D_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [1:0]              rsp_eq_q, rsp_eq_d;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    logic                    last_q, last_d;
`endif

    logic [1:0] busy_c, elig_c, grant_c, rsp_ready_c;

    // Grant depends only on req_valid and registered state.
    always_comb begin
        busy_c[0]   = (issue_valid_q && !issue_q.owner) || rsp_valid_q[0];
        busy_c[1]   = (issue_valid_q &&  issue_q.owner) || rsp_valid_q[1];
        elig_c      = {bus.req1_valid && !busy_c[1], bus.req0_valid && !busy_c[0]};
        rsp_ready_c = {bus.rsp1_ready, bus.rsp0_ready};
        grant_c     = 2'b00;
`ifdef ALU_SHARE_FIXED_PRIO_EN
        if (elig_c[0])      grant_c = 2'b01;
        else if (elig_c[1]) grant_c = 2'b10;
`else
        if (elig_c == 2'b11) grant_c = last_q ? 2'b01 : 2'b10;
        else                 grant_c = elig_c;
`endif
    end

    // Issue entry is zeroed when idle so the ALU drive is a plain register.
    always_comb begin
        issue_valid_d = |grant_c;
        issue_d       = '0;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_eq_d      = rsp_eq_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
        last_d        = last_q;
`endif
        if (grant_c[0]) begin
            issue_d = '{owner: 1'b0, ctrl: bus.req0_ctrl, op1: bus.req0_op1, op2: bus.req0_op2};
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_d  = 1'b0;
`endif
        end else if (grant_c[1]) begin
            issue_d = '{owner: 1'b1, ctrl: bus.req1_ctrl, op1: bus.req1_op1, op2: bus.req1_op2};
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_d  = 1'b1;
`endif
        end
        for (int i = 0; i < 2; i++) begin
            if (issue_valid_q && (issue_q.owner == 1'(i))) begin
                rsp_valid_d[i] = 1'b1;
                rsp_data_d[i]  = bus.alu_out;
                rsp_eq_d[i]    = bus.alu_eq;
            end else if (rsp_valid_q[i] && rsp_ready_c[i]) begin
                rsp_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid_q <= 1'b0;
            issue_q       <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_eq_q      <= '0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_q        <= 1'b1;
`endif
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_q       <= issue_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_eq_q      <= rsp_eq_d;
`ifndef ALU_SHARE_FIXED_PRIO_EN
            last_q        <= last_d;
`endif
        end
    end

    assign bus.req0_ready = grant_c[0];
    assign bus.req1_ready = grant_c[1];
    assign bus.rsp0_valid = rsp_valid_q[0];
    assign bus.rsp1_valid = rsp_valid_q[1];
    assign bus.rsp0_data  = rsp_data_q[0];
    assign bus.rsp1_data  = rsp_data_q[1];
    assign bus.rsp0_eq    = rsp_eq_q[0];
    assign bus.rsp1_eq    = rsp_eq_q[1];
    assign bus.alu_ctrl   = issue_q.ctrl;
    assign bus.alu_op1    = issue_q.op1;
    assign bus.alu_op2    = issue_q.op2;

endmodule
